// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter
// Function : Round-robin sharing of one memory line port between the I-cache
//            and D-cache miss paths, with registered outputs and grant counters.
// Revision : 1.0
// ============================================================================
module cache_mem_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic [CNT_WIDTH-1:0]  i_grants,
  output logic [CNT_WIDTH-1:0]  d_grants
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

  state_t                r_state, w_state;
  logic                  r_last_d, w_last_d;
  logic                  w_d_pend;
  logic                  w_mem_read, w_mem_write;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [LINE_WIDTH-1:0] w_mem_wdata;
  logic [LINE_WIDTH-1:0] w_i_rdata, w_d_rdata;
  logic                  w_i_resp, w_d_resp;
  logic [CNT_WIDTH-1:0]  w_i_grants, w_d_grants;

  always_comb begin
    w_state     = r_state;
    w_last_d    = r_last_d;
    w_d_pend    = d_read | d_write;
    w_mem_read  = mem_read;
    w_mem_write = mem_write;
    w_mem_addr  = mem_addr;
    w_mem_wdata = mem_wdata;
    w_i_rdata   = i_rdata;
    w_d_rdata   = d_rdata;
    w_i_resp    = 1'b0;
    w_d_resp    = 1'b0;
    w_i_grants  = i_grants;
    w_d_grants  = d_grants;

    unique case (r_state)
      IDLE: begin
        // On contention the side that did not win last time goes first.
        if (i_read && (!w_d_pend || r_last_d)) begin
          w_state    = SERVE_I;
          w_last_d   = 1'b0;
          w_mem_read = 1'b1;
          w_mem_addr = i_addr;
        end else if (w_d_pend) begin
          w_state     = SERVE_D;
          w_last_d    = 1'b1;
          w_mem_read  = ~d_write;
          w_mem_write = d_write;
          w_mem_addr  = d_addr;
          w_mem_wdata = d_wdata;
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          w_state    = RESP_I;
          w_mem_read = 1'b0;
          w_i_resp   = 1'b1;
          w_i_rdata  = mem_rdata;
          w_i_grants = i_grants + c_CNT_ONE;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          w_state     = RESP_D;
          w_mem_read  = 1'b0;
          w_mem_write = 1'b0;
          w_d_resp    = 1'b1;
          // Writebacks leave the last read line visible to the D-cache.
          if (mem_read) begin
            w_d_rdata = mem_rdata;
          end
          w_d_grants  = d_grants + c_CNT_ONE;
        end
      end
      RESP_I, RESP_D: w_state = IDLE;
      default:        w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_last_d  <= 1'b1;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_resp    <= 1'b0;
      d_resp    <= 1'b0;
      i_grants  <= '0;
      d_grants  <= '0;
    end else begin
      r_state   <= w_state;
      r_last_d  <= w_last_d;
      mem_read  <= w_mem_read;
      mem_write <= w_mem_write;
      mem_addr  <= w_mem_addr;
      mem_wdata <= w_mem_wdata;
      i_rdata   <= w_i_rdata;
      d_rdata   <= w_d_rdata;
      i_resp    <= w_i_resp;
      d_resp    <= w_d_resp;
      i_grants  <= w_i_grants;
      d_grants  <= w_d_grants;
    end
  end

endmodule
`default_nettype wire
